// File: rtl/asin_acos_pkg.sv
// Shared constants for the asin/acos unit: FSM encoding, CORDIC arctangent
// table (Q2.30) and the IEEE-754 constants used by the fast paths.
package asin_acos_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_SQRT,
    ST_CORDIC,
    ST_PACK,
    ST_DONE
  } state_t;

  localparam logic [31:0] PI_2_FIX = 32'h6487ED51;
  localparam logic [31:0] F_PI_2   = 32'h3FC90FDB;
  localparam logic [31:0] F_PI     = 32'h40490FDB;
  localparam logic [31:0] F_NAN    = 32'h7FFFFFFF;

  // atan(2^-i) in Q2.30, truncated
  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    logic [31:0] v;
    case (i)
      5'd0:  v = 32'h3243F6A8;
      5'd1:  v = 32'h1DAC6705;
      5'd2:  v = 32'h0FADBAFC;
      5'd3:  v = 32'h07F56EA6;
      5'd4:  v = 32'h03FEAB76;
      5'd5:  v = 32'h01FFD55B;
      5'd6:  v = 32'h00FFFAAA;
      5'd7:  v = 32'h007FFF55;
      5'd8:  v = 32'h003FFFEA;
      5'd9:  v = 32'h001FFFFD;
      5'd10: v = 32'h000FFFFF;
      5'd11: v = 32'h0007FFFF;
      5'd12: v = 32'h0003FFFF;
      5'd13: v = 32'h0001FFFF;
      5'd14: v = 32'h0000FFFF;
      5'd15: v = 32'h00007FFF;
      5'd16: v = 32'h00003FFF;
      5'd17: v = 32'h00001FFF;
      5'd18: v = 32'h00000FFF;
      5'd19: v = 32'h000007FF;
      5'd20: v = 32'h000003FF;
      5'd21: v = 32'h000001FF;
      5'd22: v = 32'h000000FF;
      5'd23: v = 32'h0000007F;
      5'd24: v = 32'h0000003F;
      5'd25: v = 32'h0000001F;
      5'd26: v = 32'h0000000F;
      5'd27: v = 32'h00000007;
      default: v = 32'h00000000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/asin_acos_fix_to_float.sv
// Signed fixed-point (FRAC fraction bits) to IEEE-754 single, truncating.
// Zero packs to +0.
module fix_to_float
  import asin_acos_pkg::*;
#(
  parameter int W    = 33,
  parameter int FRAC = 30
) (
  input  logic signed [W-1:0] fix,
  output logic        [31:0]  flt
);

  logic [W-1:0] mag;
  logic [W-1:0] norm;
  logic [7:0]   lead;

  always_comb begin
    mag  = fix[W-1] ? W'(-fix) : W'(fix);
    lead = '0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) lead = 8'(i);
    end
    norm = mag << (8'(W - 1) - lead);
    flt  = '0;
    if (mag != '0) flt = {fix[W-1], lead + 8'(127 - FRAC), 23'(norm >> (W - 24))};
  end

endmodule

// File: rtl/asin_acos.sv
// Sequential asin/acos: asin(x) = atan2(x, sqrt(1 - x^2)) via a bit-serial
// restoring square root followed by CORDIC vectoring, sharing one counter.
//
//   state     | meaning
//   ST_IDLE   | waiting for an operand, in_ready high
//   ST_PREP   | classify operand, fast-path result or load sqrt radicand
//   ST_SQRT   | one root bit per cycle, 31 cycles
//   ST_CORDIC | one vectoring iteration per cycle
//   ST_PACK   | select asin/acos angle and convert to float
//   ST_DONE   | result held until out_ready
module asin_acos
  import asin_acos_pkg::*;
#(
  parameter int CORDIC_ITER = 28,
  parameter int FRAC        = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in,
  input  logic        sel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [7:0] X_BIAS      = 8'(150 - FRAC);
  localparam logic [4:0] SQRT_LAST   = 5'd30;
  localparam logic [4:0] CORDIC_LAST = 5'(CORDIC_ITER - 1);

  state_t state, state_next;

  logic [31:0]        in_reg;
  logic               sel_reg;
  logic [4:0]         cnt;
  logic [61:0]        rad;
  logic [35:0]        rem;
  logic [30:0]        root;
  logic signed [33:0] cx, cy;
  logic signed [31:0] z;

  logic        sgn;
  logic [7:0]  expo;
  logic [22:0] frac;
  logic        fast;
  logic [31:0] fast_result;

  assign sgn  = in_reg[31];
  assign expo = in_reg[30:23];
  assign frac = in_reg[22:0];

  always_comb begin
    fast        = 1'b1;
    fast_result = F_NAN;
    if (expo > 8'd127 || (expo == 8'd127 && frac != '0)) fast_result = F_NAN;
    else if (expo == 8'd0) fast_result = sel_reg ? {sgn, 31'd0} : F_PI_2;
    else if (expo == 8'd127) fast_result = sel_reg ? {sgn, F_PI_2[30:0]} : (sgn ? F_PI : 32'd0);
    else if (sel_reg && expo < 8'd115) fast_result = in_reg;
    else fast = 1'b0;
  end

  // |x| < 1 on the normal path, so the Q1.30 magnitude fits in 30 bits
  logic [31:0]        x_mag;
  logic [63:0]        x_sq;
  logic [30:0]        r_fix;
  logic signed [33:0] x_fix;

  always_comb begin
    if (expo >= X_BIAS) x_mag = {8'd0, 1'b1, frac} << (expo - X_BIAS);
    else x_mag = {8'd0, 1'b1, frac} >> (X_BIAS - expo);
    x_fix = sgn ? -34'(x_mag) : 34'(x_mag);
    x_sq  = 64'(x_mag) * 64'(x_mag);
    r_fix = 31'((64'd1 << FRAC) - (x_sq >> FRAC));
  end

  logic [35:0] rem_sh, trial, rem_nx;
  logic [30:0] root_nx;
  logic        ge;

  always_comb begin
    rem_sh  = (rem << 2) | 36'(rad >> 60);
    trial   = {3'd0, root, 2'b01};
    ge      = rem_sh >= trial;
    rem_nx  = ge ? rem_sh - trial : rem_sh;
    root_nx = 31'({root, ge});
  end

  logic [4:0]         it;
  logic signed [33:0] cx_sh, cy_sh, cx_nx, cy_nx;
  logic signed [31:0] ang, z_nx;

  always_comb begin
    it    = CORDIC_LAST - cnt;
    cx_sh = cx >>> it;
    cy_sh = cy >>> it;
    ang   = signed'(atan_lut(it));
    if (cy[33]) begin
      cx_nx = cx - cy_sh;
      cy_nx = cy + cx_sh;
      z_nx  = z - ang;
    end else begin
      cx_nx = cx + cy_sh;
      cy_nx = cy - cx_sh;
      z_nx  = z + ang;
    end
  end

  // acos can reach pi, which needs one more integer bit than Z carries
  logic signed [32:0] z_ext, pack_fix;
  logic [31:0]        pack_flt;

  assign z_ext    = {z[31], z};
  assign pack_fix = sel_reg ? z_ext : $signed({1'b0, PI_2_FIX}) - z_ext;

  fix_to_float #(.W(33), .FRAC(FRAC)) u_fix_to_float (
    .fix (pack_fix),
    .flt (pack_flt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (in_valid) state_next = ST_PREP;
      ST_PREP:   state_next = fast ? ST_DONE : ST_SQRT;
      ST_SQRT:   if (cnt == '0) state_next = ST_CORDIC;
      ST_CORDIC: if (cnt == '0) state_next = ST_PACK;
      ST_PACK:   state_next = ST_DONE;
      ST_DONE:   if (out_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_reg  <= '0;
      sel_reg <= 1'b0;
      cnt     <= '0;
      rad     <= '0;
      rem     <= '0;
      root    <= '0;
      cx      <= '0;
      cy      <= '0;
      z       <= '0;
      result  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_reg  <= in;
            sel_reg <= sel;
          end
        end
        ST_PREP: begin
          if (fast) result <= fast_result;
          cnt  <= SQRT_LAST;
          rad  <= 62'(r_fix) << FRAC;
          rem  <= '0;
          root <= '0;
          cy   <= x_fix;
          z    <= '0;
        end
        ST_SQRT: begin
          rad  <= rad << 2;
          rem  <= rem_nx;
          root <= root_nx;
          cx   <= 34'(root_nx);
          cnt  <= (cnt == '0) ? CORDIC_LAST : cnt - 5'd1;
        end
        ST_CORDIC: begin
          cx  <= cx_nx;
          cy  <= cy_nx;
          z   <= z_nx;
          cnt <= cnt - 5'd1;
        end
        ST_PACK: result <= pack_flt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_asin_acos.sv
// Directed-vector bench for asin_acos: table of operands with exact or
// real-valued references, plus backpressure and mid-operation reset sequences.
module tb_asin_acos;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_w;
  logic        sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  asin_acos dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_w),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int checks = 0;
  int errors = 0;

  localparam real TOL = 2.384185791015625e-07;
  localparam real PI6 = 0.5235987755982988;
  localparam real PI3 = 1.0471975511965976;

  typedef struct {
    logic [31:0] op;
    logic        s;
    logic        approx;
    logic [31:0] want;
    real         ref_val;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    for (int k = 127; k < e; k++) m = m * 2.0;
    for (int k = e; k < 127; k++) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  task automatic chk_bits(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic chk_approx(input string name, input logic [31:0] act, input real want);
    real d;
    checks++;
    d = f2r(act) - want;
    if (d < 0.0) d = -d;
    if (d > TOL) begin
      errors++;
      $display("FAIL %s: got %h (%.9f) expected %.9f", name, act, f2r(act), want);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // Accept at the edge after driving; count edges until out_valid is seen.
  task automatic run_op(input logic [31:0] op, input logic s, output logic [31:0] res, output int lat);
    @(negedge clk);
    chk_bits("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_w     = op;
    sel      = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_w     = 32'h3E800000;
    sel      = ~s;
    lat      = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk_bits("out_valid_after_take", {31'd0, out_valid}, 32'd0);
    chk_bits("in_ready_after_take", {31'd0, in_ready}, 32'd1);
  endtask

  logic [31:0] res;
  int          lat;

  initial begin
    rst       = 1'b1;
    in_w      = '0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    vecs[0]  = '{32'h3F000000, 1'b1, 1'b1, 32'h0, PI6, 61};
    vecs[1]  = '{32'h3F000000, 1'b0, 1'b1, 32'h0, PI3, 61};
    vecs[2]  = '{32'hBF000000, 1'b1, 1'b1, 32'h0, -PI6, 61};
    vecs[3]  = '{32'hBF800000, 1'b0, 1'b0, 32'h40490FDB, 0.0, 1};
    vecs[4]  = '{32'h3F800000, 1'b0, 1'b0, 32'h00000000, 0.0, 1};
    vecs[5]  = '{32'h3F800000, 1'b1, 1'b0, 32'h3FC90FDB, 0.0, 1};
    vecs[6]  = '{32'hBF800000, 1'b1, 1'b0, 32'hBFC90FDB, 0.0, 1};
    vecs[7]  = '{32'h3F800001, 1'b1, 1'b0, 32'h7FFFFFFF, 0.0, 1};
    vecs[8]  = '{32'h7F800000, 1'b0, 1'b0, 32'h7FFFFFFF, 0.0, 1};
    vecs[9]  = '{32'hFFC00000, 1'b1, 1'b0, 32'h7FFFFFFF, 0.0, 1};
    vecs[10] = '{32'h38000000, 1'b1, 1'b0, 32'h38000000, 0.0, 1};
    vecs[11] = '{32'h38000000, 1'b0, 1'b1, 32'h0, 1.5707658092167716, 61};
    vecs[12] = '{32'h00000000, 1'b0, 1'b0, 32'h3FC90FDB, 0.0, 1};
    vecs[13] = '{32'h80000000, 1'b1, 1'b0, 32'h80000000, 0.0, 1};
    vecs[14] = '{32'h80000001, 1'b1, 1'b0, 32'h80000000, 0.0, 1};
    vecs[15] = '{32'h3F400000, 1'b0, 1'b1, 32'h0, 0.7227342478134157, 61};
    vecs[16] = '{32'h3F7FFFFF, 1'b1, 1'b1, 32'h0, 1.5704510598118954, 61};

    repeat (3) @(posedge clk);
    #1;
    chk_bits("reset_result", result, 32'h0);
    chk_bits("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk_bits("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].s, res, lat);
      chk_int($sformatf("latency[%0d]", i), lat, vecs[i].lat);
      if (vecs[i].approx) chk_approx($sformatf("value[%0d]", i), res, vecs[i].ref_val);
      else chk_bits($sformatf("value[%0d]", i), res, vecs[i].want);
      release_out();
    end

    // Backpressure: hold the result while in_valid pulses are offered.
    run_op(32'h3F000000, 1'b1, res, lat);
    chk_int("bp_latency", lat, 61);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = (k % 2 == 0);
      in_w     = 32'h3F800000;
      sel      = 1'b0;
      @(posedge clk);
      #1;
      chk_approx("bp_result", result, PI6);
      chk_bits("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk_bits("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    run_op(32'hBF800000, 1'b0, res, lat);
    chk_int("post_bp_latency", lat, 1);
    chk_bits("post_bp_value", res, 32'h40490FDB);
    release_out();

    // Reset 30 cycles into a normal-path operation.
    @(negedge clk);
    in_w     = 32'h3F000000;
    sel      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_bits("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk_bits("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk_bits("rst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h38000000, 1'b1, res, lat);
    chk_int("post_rst_fast_latency", lat, 1);
    chk_bits("post_rst_fast_value", res, 32'h38000000);
    release_out();
    run_op(32'h3F000000, 1'b0, res, lat);
    chk_int("post_rst_latency", lat, 61);
    chk_approx("post_rst_value", res, PI3);
    release_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
